// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer: buffers packed 16-bit ALSU command words in a FIFO and
// issues them one at a time to the ALSU pins. After each issue it waits out the
// ALSU latency, captures alsu_out and offers it on a valid/ready result port.
//
// Optional feature macro: ALSU_SEQ_TAG_EN
//   defined   -> adds res_tag[3:0], the 4-bit issue count of the command
//                whose result is being offered (wraps 15 -> 0)
//   undefined -> no tag port, no issue counter
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no command in flight; pops the FIFO head when one exists
// WAIT   | command driven on ALSU pins; counting down ALSU latency
// RESULT | result captured; holding res_valid until res_ready

module alsu_cmd_sequencer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int ALSU_LATENCY = 2
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [15:0]                   cmd_data,
    output logic [2:0]                    A,
    output logic [2:0]                    B,
    output logic [2:0]                    opcode,
    output logic                          cin,
    output logic                          serial_in,
    output logic                          direction,
    output logic                          red_op_A,
    output logic                          red_op_B,
    output logic                          bypass_A,
    output logic                          bypass_B,
    input  logic [5:0]                    alsu_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [5:0]                    res_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ALSU_SEQ_TAG_EN
    ,
    output logic [3:0]                    res_tag
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [15:0]   head;
    logic [2:0]    wait_cnt;

`ifdef ALSU_SEQ_TAG_EN
    logic [3:0]    issue_cnt;
    logic [3:0]    cur_tag;
`endif

    // Full blocks the producer outright, so a pop on the same edge never lets a push through.
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = (state == IDLE) && !empty;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE);

    // Command storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/wait/result sequencer; ALSU drive registers change only on a pop.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            A         <= '0;
            B         <= '0;
            opcode    <= '0;
            cin       <= 1'b0;
            serial_in <= 1'b0;
            direction <= 1'b0;
            red_op_A  <= 1'b0;
            red_op_B  <= 1'b0;
            bypass_A  <= 1'b0;
            bypass_B  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef ALSU_SEQ_TAG_EN
            issue_cnt <= '0;
            cur_tag   <= '0;
            res_tag   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        A         <= head[2:0];
                        B         <= head[5:3];
                        opcode    <= head[8:6];
                        cin       <= head[9];
                        serial_in <= head[10];
                        direction <= head[11];
                        red_op_A  <= head[12];
                        red_op_B  <= head[13];
                        bypass_A  <= head[14];
                        bypass_B  <= head[15];
                        wait_cnt  <= 3'(ALSU_LATENCY);
                        state     <= WAIT;
`ifdef ALSU_SEQ_TAG_EN
                        cur_tag   <= issue_cnt;
                        issue_cnt <= issue_cnt + 4'd1;
`endif
                    end
                end
                WAIT: begin
                    // Counter reaches zero one edge after the ALSU output settles.
                    if (wait_cnt == 3'd0) begin
                        res_data  <= alsu_out;
                        res_valid <= 1'b1;
                        state     <= RESULT;
`ifdef ALSU_SEQ_TAG_EN
                        res_tag   <= cur_tag;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Testbench for alsu_cmd_sequencer: directed vector table, multi-cycle corner
// sequences and randomized traffic checked against a queue-based reference model.
// Build with ALSU_SEQ_TAG_EN defined to also exercise res_tag.

module tb_alsu_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
    logic [5:0]  alsu_out;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_data;
    logic        busy;
    logic [3:0]  fifo_count;
`ifdef ALSU_SEQ_TAG_EN
    logic [3:0]  res_tag;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    alsu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .ALSU_LATENCY(LAT)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .cin        (cin),
        .serial_in  (serial_in),
        .direction  (direction),
        .red_op_A   (red_op_A),
        .red_op_B   (red_op_B),
        .bypass_A   (bypass_A),
        .bypass_B   (bypass_B),
        .alsu_out   (alsu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .fifo_count (fifo_count)
`ifdef ALSU_SEQ_TAG_EN
        ,
        .res_tag    (res_tag)
`endif
    );

    // ALSU stand-in: a fixed function of the command fields, two edges of latency.
    function automatic logic [5:0] alsu_fn(input logic [15:0] w);
        return w[5:0] ^ w[11:6] ^ {w[15:12], 2'b00} ^ 6'h34;
    endfunction

    logic [15:0] pins;
    logic [5:0]  stub1, stub2;
    assign pins = {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin, opcode, B, A};
    always @(posedge CLK) begin
        stub1 <= alsu_fn(pins);
        stub2 <= stub1;
    end
    assign alsu_out = stub2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending commands in a queue, one in flight, result due
    // LAT+1 edges after the issue edge, released on the handshake edge.
    logic [15:0] mq[$];
    bit          m_infl;
    bit          m_rv;
    logic [15:0] m_word;
    logic [5:0]  m_rd;
    int          m_edge;
    int          m_pop_edge;
    logic [3:0]  m_issue, m_cur_tag, m_tag;
    int          neg_cnt;
    bit          prev_busy;
    int          dut_pops[$];
    int          res_hs;
    logic [3:0]  tag_q[$];

    always @(negedge CLK) begin
        bit pop_now;
        bit push_now;
        neg_cnt++;
        if (!RST_n) begin
            mq.delete();
            m_infl    = 0;
            m_rv      = 0;
            m_word    = '0;
            m_rd      = '0;
            m_issue   = '0;
            m_cur_tag = '0;
            m_tag     = '0;
            prev_busy = 0;
        end
        chk("fifo_count", fifo_count, 32'(mq.size()));
        chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) ? 1 : 0);
        chk("busy", busy, m_infl);
        chk("res_valid", res_valid, m_rv);
        chk("res_data", res_data, m_rd);
        chk("alsu_pins", pins, m_word);
`ifdef ALSU_SEQ_TAG_EN
        chk("res_tag", res_tag, m_tag);
`endif
        if (busy === 1'b1 && !prev_busy) dut_pops.push_back(neg_cnt);
        prev_busy = (busy === 1'b1);
        if (RST_n) begin
            if (res_valid && res_ready) begin
                res_hs++;
`ifdef ALSU_SEQ_TAG_EN
                tag_q.push_back(res_tag);
`endif
            end
            pop_now  = !m_infl && (mq.size() > 0);
            push_now = cmd_valid && (mq.size() < DEPTH);
            m_edge++;
            if (m_infl && m_rv && res_ready) begin
                m_rv   = 0;
                m_infl = 0;
            end else if (m_infl && !m_rv && m_edge == m_pop_edge + LAT + 1) begin
                m_rv  = 1;
                m_rd  = alsu_fn(m_word);
                m_tag = m_cur_tag;
            end
            if (pop_now) begin
                m_word     = mq.pop_front();
                m_infl     = 1;
                m_pop_edge = m_edge;
                m_cur_tag  = m_issue;
                m_issue    = m_issue + 4'd1;
            end
            if (push_now) mq.push_back(cmd_data);
        end
    end

    task automatic push(input logic [15:0] w);
        bit ok;
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        do begin
            ok = cmd_ready;
            @(posedge CLK); #1;
            n++;
        end while (!ok && n < 300);
        chk("push_accepted", ok, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        res_ready = 1'b1;
        done = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            if (!busy && fifo_count == 0 && !res_valid) done = 1;
            else begin @(posedge CLK); #1; end
        end
        chk("drain_done", done, 1);
    endtask

    task automatic wait_rv();
        bit seen;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (res_valid) seen = 1;
            else begin @(posedge CLK); #1; end
        end
        chk("res_valid_seen", seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] word;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  op;
        logic [6:0]  flags;
        logic [5:0]  res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int hs0;
        logic [15:0] w;

        vecs[0] = '{16'h001E, 3'd6, 3'd3, 3'd0, 7'h00, 6'h2A};
        vecs[1] = '{16'hFFFF, 3'd7, 3'd7, 3'd7, 7'h7F, 6'h08};
        vecs[2] = '{16'h0000, 3'd0, 3'd0, 3'd0, 7'h00, 6'h34};
        vecs[3] = '{16'h8A5C, 3'd4, 3'd3, 3'd1, 7'h45, 6'h21};
        vecs[4] = '{16'h4321, 3'd1, 3'd4, 3'd4, 7'h21, 6'h09};

        RST_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pins", pins, 0);
        RST_n = 1'b1;
        @(posedge CLK); #1;

        // Single-command timing: fields load on the edge after the push edge,
        // result valid on the third edge after that.
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = vecs[i].word;
            @(posedge CLK); #1;
            cmd_valid = 1'b0;
            chk("vec_count_after_push", fifo_count, 1);
            chk("vec_idle_after_push", busy, 0);
            @(posedge CLK); #1;
            chk("vec_A", A, vecs[i].a);
            chk("vec_B", B, vecs[i].b);
            chk("vec_opcode", opcode, vecs[i].op);
            chk("vec_flags", pins[15:9], vecs[i].flags);
            chk("vec_busy", busy, 1);
            @(posedge CLK); #1;
            chk("vec_rv_early1", res_valid, 0);
            @(posedge CLK); #1;
            chk("vec_rv_early2", res_valid, 0);
            @(posedge CLK); #1;
            chk("vec_rv", res_valid, 1);
            chk("vec_res_data", res_data, vecs[i].res);
            @(posedge CLK); #1;
            chk("vec_rv_consumed", res_valid, 0);
            chk("vec_idle", busy, 0);
        end

        // Reset in the middle of WAIT drops the command and its result.
        cmd_valid = 1'b1;
        cmd_data  = 16'h8A5C;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_n = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_res_valid", res_valid, 0);
        chk("t1_res_data", res_data, 0);
        chk("t1_fifo_count", fifo_count, 0);
        chk("t1_cmd_ready", cmd_ready, 1);
        chk("t1_pins", pins, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("t1_no_res_valid", res_valid, 0);
        end

`ifdef ALSU_SEQ_TAG_EN
        // Issue tags count from zero after reset and wrap at 16.
        tag_q.delete();
        for (int i = 0; i < 18; i++) push(16'($urandom));
        drain();
        chk("t6_tag_total", tag_q.size(), 18);
        for (int i = 0; i < 18 && i < tag_q.size(); i++) chk("t6_tag_seq", tag_q[i], 4'(i % 16));
`endif

        // Back-pressure: nine pushes with results blocked fill the FIFO.
        res_ready = 1'b0;
        hs0 = res_hs;
        for (int i = 0; i < 9; i++) push(16'($urandom));
        chk("t3_full_count", fifo_count, 8);
        chk("t3_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_data  = 16'hBEEF;
        repeat (3) begin @(posedge CLK); #1; end
        chk("t3_no_overflow", fifo_count, 8);
        cmd_valid = 1'b0;
        drain();
        chk("t3_result_count", res_hs - hs0, 9);

        // Simultaneous push and pop at an occupancy of three.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h1111 * 16'(i + 1));
        wait_rv();
        chk("t5_count_before", fifo_count, 3);
        res_ready = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h5A5A;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        chk("t5_count_same", fifo_count, 3);
        chk("t5_busy", busy, 1);
        drain();

        // Streaming: 16 commands, opcode 0..7 twice; issue spacing is LAT+3.
        dut_pops.delete();
        for (int i = 0; i < 16; i++) begin
            w = 16'($urandom);
            w[8:6] = 3'(i % 8);
            push(w);
        end
        drain();
        chk("t4_pop_total", dut_pops.size(), 16);
        for (int i = 1; i < dut_pops.size(); i++) chk("t4_pop_spacing", dut_pops[i] - dut_pops[i-1], LAT + 3);

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_data  = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
        end
        cmd_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
